bus_ram: RTL and testbench
==========================

Name: bus_ram

Overview:
- Byte-wide RAM on the shared 8-bit processor bus. Each transfer uses two bus phases: an address phase, then a data phase.
- Writes store the bus byte into the internal array.
- Reads load the addressed byte into an internal read register, which bench and debug access hierarchically.
- Sits on the CPU bus as the main data store.

Parameters:
- WIDTH, 8, width of bus, address and data words.
- DEPTH, 2**WIDTH (256), number of storage words.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- n_reset  input  1  synchronous reset, active-high despite the name. Sampled on rising clock edge.
- enable  input  1  bus phase valid; when low, the block holds all state.
- rw  input  1  transfer direction sampled in the address phase: 1 = write, 0 = read.
- bus  input  WIDTH  carries the address in the address phase and the write data in the data phase.

Behaviour:
- Internal state, required names because benches reference them hierarchically:
  - memory[0:DEPTH-1] of WIDTH bits
  - addr_q (WIDTH)
  - op_write_q (1)
  - rdata_q (WIDTH)
  - state, enum {ADDR, DATA}
- Reset (n_reset=1 at a rising edge):
  - state=ADDR, addr_q=0, op_write_q=0, rdata_q=0.
  - All memory words cleared to 0.
  - Reset has priority over everything; reset mid-transfer aborts the transfer and performs no write.
- State ADDR:
  - enable=1 at the edge: addr_q<=bus, op_write_q<=rw, state<=DATA.
  - enable=0: hold.
- State DATA:
  - enable=1 at the edge:
    - op_write_q=1: memory[addr_q]<=bus.
    - op_write_q=0: rdata_q<=memory[addr_q].
    - Then state<=ADDR.
  - enable=0: wait in DATA indefinitely, no state change.
- rw in the data phase is ignored; direction is fixed by the address-phase sample.
- Latency:
  - Write is visible in memory immediately after the data-phase rising edge.
  - Read data appears in rdata_q after the same edge.
- Back-to-back transfers are allowed. The next address phase may follow in the cycle right after a data phase.
- Address covers the full DEPTH range; no wrap or out-of-range case exists when DEPTH = 2**WIDTH.
- Read of a just-written address in the next transfer returns the new value.
- No combinational paths; bus is never driven by this block.

Decomposition:
- Shared package cuca_pkg holds:
  - WIDTH constant (8)
  - typedef word_t (logic [7:0])
  - enum ram_phase_t {ADDR, DATA}
  - rw encoding constants RW_READ=0, RW_WRITE=1
- Single module, no sub-modules. The storage array is inferred inside it.

Test Plan:
- Reset: hold n_reset=1 for one edge → state=ADDR, addr_q=0, rdata_q=0, memory[10]=0.
- Single write:
  - Release reset. Drive enable=1, rw=1, bus=10 for one cycle, then bus=15 for one cycle.
  - At the next falling edge, memory[10]=15 and no other word has changed.
- Read back:
  - After the write above, drive enable=1, rw=0, bus=10, then one data-phase cycle with any bus value.
  - rdata_q=15 and memory is unchanged.
- Stall:
  - Address phase bus=0x20 with rw=1, then enable=0 for 3 cycles (state stays DATA), then enable=1 with bus=0xA5.
  - Result: memory[0x20]=0xA5.
- Reset mid-transfer:
  - Address phase bus=0x30 with rw=1, then the data edge with n_reset=1 and bus=0x77.
  - Result: memory[0x30]=0, state=ADDR.
- Boundary addresses and back-to-back:
  - Write 0x11 to address 0x00, then immediately write 0x22 to address 0xFF.
  - Read both back: rdata_q=0x11 and 0x22 respectively.

Source files
------------

// File: rtl/cuca_pkg.sv
// Shared bus definitions for the 8-bit processor bus peripherals.
package cuca_pkg;

  localparam int WIDTH = 8;

  typedef logic [7:0] word_t;

  typedef enum logic {
    ADDR = 1'b0,
    DATA = 1'b1
  } ram_phase_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

endpackage

// File: rtl/bus_ram.sv
// Byte-wide RAM on the shared processor bus: address phase, then data phase.
// Reads land in rdata_q, which is observed hierarchically rather than driven out.
module bus_ram
  import cuca_pkg::*;
#(
  parameter int WIDTH = cuca_pkg::WIDTH,
  parameter int DEPTH = 2 ** WIDTH
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic             enable,
  input  logic             rw,
  input  logic [WIDTH-1:0] bus
);

  logic [WIDTH-1:0] memory [0:DEPTH-1];
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] addr_d;
  logic             op_write_q;
  logic             op_write_d;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;
  ram_phase_t       state;
  ram_phase_t       state_d;
  logic             mem_we;

  always_comb begin
    state_d    = state;
    addr_d     = addr_q;
    op_write_d = op_write_q;
    rdata_d    = rdata_q;
    mem_we     = 1'b0;
    if (enable) begin
      case (state)
        ADDR: begin
          addr_d     = bus;
          op_write_d = rw;
          state_d    = DATA;
        end
        DATA: begin
          // Direction comes from the address-phase sample; rw is ignored here.
          if (op_write_q == RW_WRITE) begin
            mem_we = 1'b1;
          end else begin
            rdata_d = memory[addr_q];
          end
          state_d = ADDR;
        end
        default: state_d = ADDR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (n_reset) begin
      state      <= ADDR;
      addr_q     <= '0;
      op_write_q <= RW_READ;
      rdata_q    <= '0;
    end else begin
      state      <= state_d;
      addr_q     <= addr_d;
      op_write_q <= op_write_d;
      rdata_q    <= rdata_d;
    end
  end

  // Reset clears the whole array, so storage lives in fabric registers.
  always_ff @(posedge clock) begin
    if (n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        memory[i] <= '0;
      end
    end else if (mem_we) begin
      memory[addr_q] <= bus;
    end
  end

endmodule

// File: tb/tb_bus_ram.sv
// Directed checks of bus_ram: reset, write, read-back, stall, abort, boundary addresses.
module tb_bus_ram;
  import cuca_pkg::*;

  logic       clock;
  logic       n_reset;
  logic       enable;
  logic       rw;
  logic [7:0] bus;

  int checks = 0;
  int errors = 0;

  bus_ram dut (
    .clock   (clock),
    .n_reset (n_reset),
    .enable  (enable),
    .rw      (rw),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
  task automatic cyc(input logic en, input logic dir, input logic [7:0] b, input logic rst);
    n_reset = rst;
    enable  = en;
    rw      = dir;
    bus     = b;
    @(posedge clock);
    @(negedge clock);
    $display("cycle rst=%0b en=%0b rw=%0b bus=%02h -> state=%0d addr_q=%02h rdata_q=%02h",
             rst, en, dir, b, dut.state, dut.addr_q, dut.rdata_q);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_reset = 1'b1;
    enable  = 1'b0;
    rw      = 1'b0;
    bus     = 8'h00;
    @(negedge clock);

    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    check("reset_state", 32'(dut.state), 32'(ADDR));
    check("reset_addr", 32'(dut.addr_q), 32'h0);
    check("reset_opw", 32'(dut.op_write_q), 32'h0);
    check("reset_rdata", 32'(dut.rdata_q), 32'h0);
    check("reset_mem10", 32'(dut.memory[10]), 32'h0);

    // Idle in ADDR holds everything
    cyc(1'b0, 1'b1, 8'h44, 1'b0);
    check("idle_state", 32'(dut.state), 32'(ADDR));
    check("idle_addr", 32'(dut.addr_q), 32'h0);

    // Single write 15 -> [10]
    cyc(1'b1, 1'b1, 8'd10, 1'b0);
    check("wr_addr_state", 32'(dut.state), 32'(DATA));
    check("wr_addr_q", 32'(dut.addr_q), 32'd10);
    check("wr_opw", 32'(dut.op_write_q), 32'h1);
    cyc(1'b1, 1'b1, 8'd15, 1'b0);
    check("wr_mem10", 32'(dut.memory[10]), 32'd15);
    check("wr_mem9", 32'(dut.memory[9]), 32'h0);
    check("wr_mem11", 32'(dut.memory[11]), 32'h0);
    check("wr_state", 32'(dut.state), 32'(ADDR));

    // Read back [10]; rw high in data phase must not turn it into a write
    cyc(1'b1, 1'b0, 8'd10, 1'b0);
    cyc(1'b1, 1'b1, 8'h99, 1'b0);
    check("rd_rdata", 32'(dut.rdata_q), 32'd15);
    check("rd_mem10", 32'(dut.memory[10]), 32'd15);
    check("rd_mem99", 32'(dut.memory[8'h99]), 32'h0);

    // Stall in DATA for 3 cycles
    cyc(1'b1, 1'b1, 8'h20, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'h55, 1'b0);
      check("stall_state", 32'(dut.state), 32'(DATA));
      check("stall_mem20", 32'(dut.memory[8'h20]), 32'h0);
    end
    cyc(1'b1, 1'b0, 8'hA5, 1'b0);
    check("stall_mem20_done", 32'(dut.memory[8'h20]), 32'hA5);
    check("stall_mem55", 32'(dut.memory[8'h55]), 32'h0);

    // Reset on the data edge aborts the write and clears the array
    cyc(1'b1, 1'b1, 8'h30, 1'b0);
    cyc(1'b1, 1'b1, 8'h77, 1'b1);
    check("abort_mem30", 32'(dut.memory[8'h30]), 32'h0);
    check("abort_state", 32'(dut.state), 32'(ADDR));
    check("abort_mem10", 32'(dut.memory[10]), 32'h0);
    check("abort_mem20", 32'(dut.memory[8'h20]), 32'h0);

    // Boundary addresses, back-to-back
    cyc(1'b1, 1'b1, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 8'h11, 1'b0);
    cyc(1'b1, 1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 1'b1, 8'h22, 1'b0);
    check("bnd_mem00", 32'(dut.memory[8'h00]), 32'h11);
    check("bnd_memff", 32'(dut.memory[8'hFF]), 32'h22);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h5A, 1'b0);
    check("bnd_rd00", 32'(dut.rdata_q), 32'h11);
    cyc(1'b1, 1'b0, 8'hFF, 1'b0);
    cyc(1'b1, 1'b0, 8'h5A, 1'b0);
    check("bnd_rdff", 32'(dut.rdata_q), 32'h22);

    // Overwrite then read in the very next transfer
    cyc(1'b1, 1'b1, 8'hFF, 1'b0);
    cyc(1'b1, 1'b1, 8'h3C, 1'b0);
    cyc(1'b1, 1'b0, 8'hFF, 1'b0);
    cyc(1'b1, 1'b1, 8'h00, 1'b0);
    check("raw_rdff", 32'(dut.rdata_q), 32'h3C);
    check("raw_mem00", 32'(dut.memory[8'h00]), 32'h11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
